// File: rtl/pfb_input_sequencer.sv
// pfb_input_sequencer
// Frames a raw complex sample stream for the 2x-oversampled polyphase
// filterbank input mux. Samples are tagged with a channel index, aligned to
// an external frame sync, buffered in a FIFO and handed to the PFB no more
// often than once every MIN_GAP cycles.
//
// Ports:
//   Clk, Rst             clock, asynchronous active-high reset
//   Enable               sequencer enable; low flushes and re-arms for sync
//   Input_valid/_sync    sample strobe and "this sample is channel 0" marker
//   Input_i/_q           signed sample
//   Output_valid         one-cycle strobe to the PFB mux
//   Output_channel/_last channel index and end-of-frame flag
//   Output_i/_q          signed sample, passed through unmodified
//   Status_fifo_level    FIFO occupancy
//   Error_fifo_overflow  one-cycle pulse when a sample had to be dropped
//   Error_sync_lost      one-cycle pulse when sync arrived mid-frame

module pfb_input_sequencer #(
    parameter int NUM_CHANNELS        = 16,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 16,
    parameter int FIFO_DEPTH          = 32,
    parameter int MIN_GAP             = 2
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Enable,
    input  logic                           Input_valid,
    input  logic                           Input_sync,
    input  logic signed [DATA_WIDTH-1:0]   Input_i,
    input  logic signed [DATA_WIDTH-1:0]   Input_q,
    output logic                           Output_valid,
    output logic [CHANNEL_INDEX_WIDTH-1:0] Output_channel,
    output logic                           Output_last,
    output logic signed [DATA_WIDTH-1:0]   Output_i,
    output logic signed [DATA_WIDTH-1:0]   Output_q,
    output logic [$clog2(FIFO_DEPTH):0]    Status_fifo_level,
    output logic                           Error_fifo_overflow,
    output logic                           Error_sync_lost
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int ENTRY_W = CHANNEL_INDEX_WIDTH + 2 * DATA_WIDTH;

    typedef enum logic {
        S_WAIT_SYNC,
        S_RUN
    } state_t;

    state_t                           state;
    logic [CHANNEL_INDEX_WIDTH-1:0]   chanCount;
    logic [PTR_W-1:0]                 wrPtr;
    logic [PTR_W-1:0]                 rdPtr;
    logic [GAP_W-1:0]                 gapCount;
    logic [ENTRY_W-1:0]               mem [FIFO_DEPTH];

    logic                             stageValid;
    logic [CHANNEL_INDEX_WIDTH-1:0]   stageChannel;
    logic signed [DATA_WIDTH-1:0]     stageI;
    logic signed [DATA_WIDTH-1:0]     stageQ;

    logic                             syncLost;
    logic                             startFrame;
    logic                             pop;
    logic                             overflow;
    logic                             push;
    logic                             flush;
    logic                             killOut;
    logic [CHANNEL_INDEX_WIDTH-1:0]   wrChannel;
    logic [PTR_W-1:0]                 wrAddr;
    logic [ENTRY_W-1:0]               rdEntry;

    // A sync that lands mid-frame restarts the frame. The pop is held off in
    // that cycle so nothing from the abandoned frame slips out while the FIFO
    // is being flushed. A pop in the same cycle as a write into a full FIFO
    // frees a slot, so that case is not an overflow.
    assign syncLost   = Enable && (state == S_RUN) && Input_valid && Input_sync
                        && (chanCount != '0);
    assign startFrame = Enable && (state == S_WAIT_SYNC) && Input_valid && Input_sync;
    assign pop        = Enable && (Status_fifo_level != '0) && (gapCount == '0) && !syncLost;
    assign overflow   = Enable && (state == S_RUN) && Input_valid && !syncLost
                        && (Status_fifo_level == LEVEL_W'(FIFO_DEPTH)) && !pop;
    assign push       = startFrame || (Enable && (state == S_RUN) && Input_valid && !overflow);
    assign flush      = !Enable || syncLost || overflow;
    assign killOut    = !Enable || syncLost;
    assign wrChannel  = (startFrame || syncLost) ? '0 : chanCount;
    assign wrAddr     = syncLost ? '0 : wrPtr;
    assign rdEntry    = mem[rdPtr];

    // Sample storage. A mid-frame sync restarts the FIFO at slot 0 so the
    // sync sample becomes the only entry after the flush.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wrAddr] <= {wrChannel, Input_i, Input_q};
        end
    end

    // Framing state, FIFO pointers, pacing counter and the registered output
    // path. The pop loads a one-entry stage; the outputs follow a cycle later.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state               <= S_WAIT_SYNC;
            chanCount           <= '0;
            wrPtr               <= '0;
            rdPtr               <= '0;
            Status_fifo_level   <= '0;
            gapCount            <= '0;
            stageValid          <= 1'b0;
            stageChannel        <= '0;
            stageI              <= '0;
            stageQ              <= '0;
            Output_valid        <= 1'b0;
            Output_channel      <= '0;
            Output_last         <= 1'b0;
            Output_i            <= '0;
            Output_q            <= '0;
            Error_fifo_overflow <= 1'b0;
            Error_sync_lost     <= 1'b0;
        end else begin
            if (!Enable || overflow) begin
                state     <= S_WAIT_SYNC;
                chanCount <= '0;
            end else if (startFrame || syncLost) begin
                state     <= S_RUN;
                chanCount <= CHANNEL_INDEX_WIDTH'(1);
            end else if (push) begin
                chanCount <= chanCount + CHANNEL_INDEX_WIDTH'(1);
            end

            if (syncLost) begin
                wrPtr             <= PTR_W'(1);
                rdPtr             <= '0;
                Status_fifo_level <= LEVEL_W'(1);
            end else if (flush) begin
                wrPtr             <= '0;
                rdPtr             <= '0;
                Status_fifo_level <= '0;
            end else begin
                if (push) begin
                    wrPtr <= wrPtr + PTR_W'(1);
                end
                if (pop) begin
                    rdPtr <= rdPtr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   Status_fifo_level <= Status_fifo_level + LEVEL_W'(1);
                    2'b01:   Status_fifo_level <= Status_fifo_level - LEVEL_W'(1);
                    default: Status_fifo_level <= Status_fifo_level;
                endcase
            end

            if (flush) begin
                gapCount <= '0;
            end else if (pop) begin
                gapCount <= GAP_W'(MIN_GAP - 1);
            end else if (gapCount != '0) begin
                gapCount <= gapCount - GAP_W'(1);
            end

            stageValid <= killOut ? 1'b0 : pop;
            if (pop) begin
                stageChannel <= rdEntry[ENTRY_W-1 -: CHANNEL_INDEX_WIDTH];
                stageI       <= $signed(rdEntry[2*DATA_WIDTH-1 -: DATA_WIDTH]);
                stageQ       <= $signed(rdEntry[DATA_WIDTH-1:0]);
            end

            Output_valid <= stageValid && !killOut;
            if (stageValid && !killOut) begin
                Output_channel <= stageChannel;
                Output_last    <= (stageChannel == CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1));
                Output_i       <= stageI;
                Output_q       <= stageQ;
            end

            Error_fifo_overflow <= overflow;
            Error_sync_lost     <= syncLost;
        end
    end

endmodule

// File: tb/tb_pfb_input_sequencer.sv
// Self-checking bench for pfb_input_sequencer. Expected samples are queued
// as they are driven and compared in order whenever Output_valid is seen.

module tb_pfb_input_sequencer;

    localparam int NCH   = 16;
    localparam int CIW   = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 32;
    localparam int GAP   = 2;
    localparam int LW    = 6;

    logic                    Clk = 1'b0;
    logic                    Rst;
    logic                    Enable;
    logic                    Input_valid;
    logic                    Input_sync;
    logic signed [DW-1:0]    Input_i;
    logic signed [DW-1:0]    Input_q;
    logic                    Output_valid;
    logic [CIW-1:0]          Output_channel;
    logic                    Output_last;
    logic signed [DW-1:0]    Output_i;
    logic signed [DW-1:0]    Output_q;
    logic [LW-1:0]           Status_fifo_level;
    logic                    Error_fifo_overflow;
    logic                    Error_sync_lost;

    typedef struct packed {
        logic [CIW-1:0] ch;
        logic           last;
        logic [DW-1:0]  i;
        logic [DW-1:0]  q;
    } expEntry_t;

    expEntry_t sb[$];
    expEntry_t expHead;
    expEntry_t gotEntry;

    int checkCount      = 0;
    int passCount       = 0;
    int cycleCount      = 0;
    int outCount        = 0;
    int ovfCount        = 0;
    int syncLostCount   = 0;
    int firstValidCycle = -1;
    int lastValidCycle  = -1;

    pfb_input_sequencer #(
        .NUM_CHANNELS (NCH),
        .DATA_WIDTH   (DW),
        .FIFO_DEPTH   (DEPTH),
        .MIN_GAP      (GAP)
    ) dut (
        .Clk                 (Clk),
        .Rst                 (Rst),
        .Enable              (Enable),
        .Input_valid         (Input_valid),
        .Input_sync          (Input_sync),
        .Input_i             (Input_i),
        .Input_q             (Input_q),
        .Output_valid        (Output_valid),
        .Output_channel      (Output_channel),
        .Output_last         (Output_last),
        .Output_i            (Output_i),
        .Output_q            (Output_q),
        .Status_fifo_level   (Status_fifo_level),
        .Error_fifo_overflow (Error_fifo_overflow),
        .Error_sync_lost     (Error_sync_lost)
    );

    // Free-running clock and cycle counter used for latency/spacing checks.
    always #5 Clk = ~Clk;

    always @(posedge Clk) cycleCount++;

    // Output monitor: on the falling edge, count error pulses and compare
    // every delivered sample with the head of the scoreboard.
    always @(negedge Clk) begin
        if (Error_fifo_overflow === 1'b1) ovfCount++;
        if (Error_sync_lost === 1'b1) syncLostCount++;
        if (Output_valid === 1'b1) begin
            outCount++;
            if (firstValidCycle < 0) firstValidCycle = cycleCount;
            if (lastValidCycle >= 0) begin
                checkCount++;
                if (cycleCount - lastValidCycle < GAP)
                    $display("[TB] FAIL output_spacing: got %0d cycles, required >= %0d",
                             cycleCount - lastValidCycle, GAP);
                else
                    passCount++;
            end
            lastValidCycle = cycleCount;
            gotEntry = {Output_channel, Output_last, Output_i, Output_q};
            checkCount++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_output: got ch=%0d i=%0d q=%0d, required no output",
                         Output_channel, Output_i, Output_q);
            end else begin
                expHead = sb.pop_front();
                if (gotEntry !== expHead)
                    $display("[TB] FAIL scoreboard: got ch=%0d last=%0d i=%0d q=%0d, required ch=%0d last=%0d i=%0d q=%0d",
                             gotEntry.ch, gotEntry.last, $signed(gotEntry.i), $signed(gotEntry.q),
                             expHead.ch, expHead.last, $signed(expHead.i), $signed(expHead.q));
                else
                    passCount++;
            end
        end
    end

    // Drive one cycle of input and return 1 time unit after the clock edge.
    task automatic applyStimulus(input logic v, input logic s, input int k);
        int negK;
        negK        = -k;
        Input_valid = v;
        Input_sync  = s;
        Input_i     = k[DW-1:0];
        Input_q     = negK[DW-1:0];
        @(posedge Clk);
        #1;
    endtask

    task automatic pushExpect(input int ch, input int k);
        expEntry_t e;
        int negK;
        negK   = -k;
        e.ch   = ch[CIW-1:0];
        e.last = (ch == NCH - 1);
        e.i    = k[DW-1:0];
        e.q    = negK[DW-1:0];
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        Input_valid = 1'b0;
        Input_sync  = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        Rst         = 1'b1;
        Enable      = 1'b1;
        Input_valid = 1'b0;
        Input_sync  = 1'b0;
        Input_i     = '0;
        Input_q     = '0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        sb.delete();
    endtask

    // Send count samples starting at channel 0, data base+j, expected in order.
    task automatic sendFrame(input int base, input int count, input bit withSync);
        for (int j = 0; j < count; j++) begin
            pushExpect(j % NCH, base + j);
            applyStimulus(1'b1, withSync && (j == 0), base + j);
        end
    endtask

    task automatic waitDrain(input int maxCycles);
        Input_valid = 1'b0;
        Input_sync  = 1'b0;
        for (int c = 0; c < maxCycles && sb.size() != 0; c++) @(posedge Clk);
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst         = 1'b1;
        Enable      = 1'b1;
        Input_valid = 1'b0;
        Input_sync  = 1'b0;
        Input_i     = '0;
        Input_q     = '0;
        #12;
        checkCount++;
        if (Output_valid !== 1'b0)
            $display("[TB] FAIL reset_valid: got %b, required 0", Output_valid);
        else passCount++;
        checkCount++;
        if ({Output_channel, Output_last, Output_i, Output_q} !== '0)
            $display("[TB] FAIL reset_data: got ch=%0d last=%0d i=%0d q=%0d, required all 0",
                     Output_channel, Output_last, Output_i, Output_q);
        else passCount++;
        checkCount++;
        if (Status_fifo_level !== '0)
            $display("[TB] FAIL reset_level: got %0d, required 0", Status_fifo_level);
        else passCount++;
        checkCount++;
        if ({Error_fifo_overflow, Error_sync_lost} !== 2'b00)
            $display("[TB] FAIL reset_errors: got %b, required 00",
                     {Error_fifo_overflow, Error_sync_lost});
        else passCount++;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int acceptCycle;
        int outStart;
        doReset();
        firstValidCycle = -1;
        outStart        = outCount;
        acceptCycle     = 0;
        for (int j = 0; j < 32; j++) begin
            pushExpect(j % NCH, j);
            applyStimulus(1'b1, j == 0, j);
            if (j == 0) begin
                acceptCycle = cycleCount;
                checkCount++;
                if (Status_fifo_level !== LW'(1))
                    $display("[TB] FAIL b2b_level_first_write: got %0d, required 1", Status_fifo_level);
                else passCount++;
            end
            if (j == 1) begin
                checkCount++;
                if (Status_fifo_level !== LW'(1))
                    $display("[TB] FAIL b2b_level_write_and_pop: got %0d, required 1", Status_fifo_level);
                else passCount++;
            end
        end
        waitDrain(200);
        checkCount++;
        if (sb.size() != 0)
            $display("[TB] FAIL b2b_drain: got %0d pending, required 0", sb.size());
        else passCount++;
        checkCount++;
        if (firstValidCycle - acceptCycle != 2)
            $display("[TB] FAIL b2b_latency: got %0d cycles, required 2", firstValidCycle - acceptCycle);
        else passCount++;
        checkCount++;
        if (lastValidCycle - firstValidCycle != 62)
            $display("[TB] FAIL b2b_span: got %0d cycles, required 62", lastValidCycle - firstValidCycle);
        else passCount++;
        checkCount++;
        if (outCount - outStart != 32)
            $display("[TB] FAIL b2b_count: got %0d outputs, required 32", outCount - outStart);
        else passCount++;
    endtask

    task automatic test_presync_discard();
        int outStart;
        doReset();
        outStart = outCount;
        for (int j = 0; j < 10; j++) applyStimulus(1'b1, 1'b0, 100 + j);
        sendFrame(200, 16, 1'b1);
        waitDrain(200);
        checkCount++;
        if (sb.size() != 0)
            $display("[TB] FAIL presync_drain: got %0d pending, required 0", sb.size());
        else passCount++;
        checkCount++;
        if (outCount - outStart != 16)
            $display("[TB] FAIL presync_count: got %0d outputs, required 16", outCount - outStart);
        else passCount++;
    endtask

    task automatic test_sync_lost();
        doReset();
        syncLostCount = 0;
        sendFrame(300, 5, 1'b1);
        applyStimulus(1'b1, 1'b1, 305);
        sb.delete();
        pushExpect(0, 305);
        for (int j = 1; j < NCH; j++) begin
            pushExpect(j, 305 + j);
            applyStimulus(1'b1, 1'b0, 305 + j);
        end
        waitDrain(200);
        checkCount++;
        if (sb.size() != 0)
            $display("[TB] FAIL synclost_drain: got %0d pending, required 0", sb.size());
        else passCount++;
        checkCount++;
        if (syncLostCount != 1)
            $display("[TB] FAIL synclost_pulses: got %0d, required 1", syncLostCount);
        else passCount++;
    endtask

    // Input every cycle, one pop every 2 cycles: after the write at edge j the
    // level is ceil((j+1)/2), so it first reads 32 after sample 62; sample 63
    // coincides with a pop and sample 64 overflows. Pops at edges 1,3..63
    // deliver samples 0..31.
    task automatic test_overflow();
        int outStart;
        doReset();
        ovfCount = 0;
        outStart = outCount;
        for (int j = 0; j < 70; j++) begin
            pushExpect(j % NCH, 1000 + j);
            applyStimulus(1'b1, j == 0, 1000 + j);
            if (j == 62) begin
                checkCount++;
                if (Status_fifo_level !== LW'(32) || ovfCount != 0)
                    $display("[TB] FAIL ovf_full_level: got level=%0d pulses=%0d, required level=32 pulses=0",
                             Status_fifo_level, ovfCount);
                else passCount++;
            end
        end
        idle(6);
        checkCount++;
        if (ovfCount != 1)
            $display("[TB] FAIL ovf_pulses: got %0d, required 1", ovfCount);
        else passCount++;
        checkCount++;
        if (outCount - outStart != 32)
            $display("[TB] FAIL ovf_delivered: got %0d outputs, required 32", outCount - outStart);
        else passCount++;
        checkCount++;
        if (Status_fifo_level !== '0)
            $display("[TB] FAIL ovf_level_flushed: got %0d, required 0", Status_fifo_level);
        else passCount++;
        sb.delete();
        outStart = outCount;
        for (int j = 0; j < 5; j++) applyStimulus(1'b1, 1'b0, 1100 + j);
        idle(6);
        checkCount++;
        if (outCount != outStart)
            $display("[TB] FAIL ovf_wait_sync: got %0d outputs, required 0", outCount - outStart);
        else passCount++;
        sendFrame(1200, 16, 1'b1);
        waitDrain(200);
        checkCount++;
        if (sb.size() != 0)
            $display("[TB] FAIL ovf_resync_drain: got %0d pending, required 0", sb.size());
        else passCount++;
    endtask

    task automatic test_async_reset();
        int outStart;
        doReset();
        sendFrame(3000, 8, 1'b1);
        #2;
        Rst = 1'b1;
        #1;
        checkCount++;
        if (Output_valid !== 1'b0)
            $display("[TB] FAIL areset_valid: got %b, required 0", Output_valid);
        else passCount++;
        checkCount++;
        if ({Output_channel, Output_last, Output_i, Output_q} !== '0)
            $display("[TB] FAIL areset_data: got ch=%0d i=%0d q=%0d, required all 0",
                     Output_channel, Output_i, Output_q);
        else passCount++;
        checkCount++;
        if (Status_fifo_level !== '0)
            $display("[TB] FAIL areset_level: got %0d, required 0", Status_fifo_level);
        else passCount++;
        sb.delete();
        @(posedge Clk);
        #1;
        Rst      = 1'b0;
        outStart = outCount;
        for (int j = 0; j < 10; j++) applyStimulus(1'b1, 1'b0, 3100 + j);
        idle(6);
        checkCount++;
        if (outCount != outStart)
            $display("[TB] FAIL areset_nosync: got %0d outputs, required 0", outCount - outStart);
        else passCount++;
    endtask

    // 16 back-to-back samples leave 8 queued (level ceil(16/2)); pops at
    // edges 1..13 have delivered samples 0..6 when Enable drops.
    task automatic test_enable_drop();
        int outStart;
        doReset();
        outStart = outCount;
        sendFrame(2000, 16, 1'b1);
        checkCount++;
        if (Status_fifo_level !== LW'(8))
            $display("[TB] FAIL endrop_level_before: got %0d, required 8", Status_fifo_level);
        else passCount++;
        Enable      = 1'b0;
        Input_valid = 1'b0;
        Input_sync  = 1'b0;
        @(posedge Clk);
        #1;
        sb.delete();
        checkCount++;
        if (Status_fifo_level !== '0 || Output_valid !== 1'b0)
            $display("[TB] FAIL endrop_flush: got level=%0d valid=%b, required level=0 valid=0",
                     Status_fifo_level, Output_valid);
        else passCount++;
        checkCount++;
        if (outCount - outStart != 7)
            $display("[TB] FAIL endrop_delivered: got %0d outputs, required 7", outCount - outStart);
        else passCount++;
        outStart = outCount;
        idle(4);
        Enable = 1'b1;
        for (int j = 0; j < 4; j++) applyStimulus(1'b1, 1'b0, 2050 + j);
        idle(6);
        checkCount++;
        if (outCount != outStart)
            $display("[TB] FAIL endrop_quiet: got %0d outputs, required 0", outCount - outStart);
        else passCount++;
        sendFrame(2100, 16, 1'b1);
        waitDrain(200);
        checkCount++;
        if (sb.size() != 0)
            $display("[TB] FAIL endrop_resync_drain: got %0d pending, required 0", sb.size());
        else passCount++;
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        test_reset();
        test_back_to_back();
        test_presync_discard();
        test_sync_lost();
        test_overflow();
        test_async_reset();
        test_enable_drop();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop in case a scenario never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
